// File: rtl/clk_meas.sv
// Measures an asynchronous waveform in clk cycles: delay from start to the first
// clean rising edge, high time, low time and saturated period of one full cycle.
module clk_meas #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] phase_cyc,
    output logic [CNT_W-1:0] ton_cyc,
    output logic [CNT_W-1:0] toff_cyc,
    output logic [CNT_W-1:0] period_cyc,
    output logic             overflow
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RISE = 3'd1,
        MEAS_HIGH = 3'd2,
        MEAS_LOW  = 3'd3,
        FIN       = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_phase;
    logic [CNT_W-1:0]       r_high;
    logic [CNT_W-1:0]       r_low;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ovf;
    logic [CNT_W-1:0]       r_phase_out;
    logic [CNT_W-1:0]       r_ton_out;
    logic [CNT_W-1:0]       r_toff_out;
    logic [CNT_W-1:0]       r_period_out;

    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_abort;
    logic [CNT_W:0]         w_sum;
    logic [CNT_W-1:0]       w_period;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= w_sync;
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_prev;
    assign w_fall = ~w_sync & r_prev;

    // A counter already at all-ones that would have to count again ends the run
    assign w_abort = ((r_state == WAIT_RISE) && !w_rise && (r_phase == CNT_MAX)) ||
                     ((r_state == MEAS_HIGH) && !w_fall && (r_high  == CNT_MAX)) ||
                     ((r_state == MEAS_LOW)  && !w_rise && (r_low   == CNT_MAX));

    assign w_sum    = {1'b0, r_high} + {1'b0, r_low};
    assign w_period = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_phase      <= '0;
            r_high       <= '0;
            r_low        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
            r_phase_out  <= '0;
            r_ton_out    <= '0;
            r_toff_out   <= '0;
            r_period_out <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state      <= FIN;
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
                r_ovf        <= 1'b1;
                r_phase_out  <= CNT_MAX;
                r_ton_out    <= CNT_MAX;
                r_toff_out   <= CNT_MAX;
                r_period_out <= CNT_MAX;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state <= WAIT_RISE;
                            r_phase <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    WAIT_RISE: begin
                        if (w_rise) begin
                            r_state <= MEAS_HIGH;
                            r_high  <= CNT_ONE;
                        end else begin
                            r_phase <= r_phase + CNT_ONE;
                        end
                    end
                    MEAS_HIGH: begin
                        if (w_fall) begin
                            r_state <= MEAS_LOW;
                            r_low   <= CNT_ONE;
                        end else begin
                            r_high <= r_high + CNT_ONE;
                        end
                    end
                    MEAS_LOW: begin
                        if (w_rise) begin
                            r_state      <= FIN;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_ovf        <= 1'b0;
                            r_phase_out  <= r_phase;
                            r_ton_out    <= r_high;
                            r_toff_out   <= r_low;
                            r_period_out <= w_period;
                        end else begin
                            r_low <= r_low + CNT_ONE;
                        end
                    end
                    FIN: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_ovf;
    assign phase_cyc  = r_phase_out;
    assign ton_cyc    = r_ton_out;
    assign toff_cyc   = r_toff_out;
    assign period_cyc = r_period_out;

endmodule

// File: tb/tb_clk_meas.sv
// Scoreboard bench for clk_meas: waveforms are built as per-cycle sample queues and a
// run-length reference model predicts results and the done cycle for each start.
module tb_clk_meas;

    localparam int CNT_W = 8;
    localparam int S     = 2;
    localparam int MAXV  = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] phase_cyc;
    logic [CNT_W-1:0] ton_cyc;
    logic [CNT_W-1:0] toff_cyc;
    logic [CNT_W-1:0] period_cyc;
    logic             overflow;

    clk_meas #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .phase_cyc  (phase_cyc),
        .ton_cyc    (ton_cyc),
        .toff_cyc   (toff_cyc),
        .period_cyc (period_cyc),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int phase;
        int ton;
        int toff;
        int period;
        int ovf;
        int done_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    bit   wq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit smp(input int n);
        return wq[(n < wq.size()) ? n : wq.size() - 1];
    endfunction

    task automatic put(input bit v, input int n);
        repeat (n) wq.push_back(v);
    endtask

    // wq[n] is the value the first sync stage captures n edges after the start edge
    function automatic exp_t model(input int e0);
        exp_t r;
        int k = 0;
        int h = 0;
        int l = 0;
        int f;
        r.phase = MAXV; r.ton = MAXV; r.toff = MAXV; r.period = MAXV; r.ovf = 1;
        for (int n = 1; n <= MAXV + 1 - S; n++) begin
            if (smp(n) && !smp(n - 1)) begin
                k = n;
                break;
            end
        end
        if (k == 0) begin
            r.done_cyc = e0 + MAXV + 1;
            return r;
        end
        while (h <= MAXV && smp(k + h)) h++;
        if (h > MAXV) begin
            r.done_cyc = e0 + k + S + MAXV;
            return r;
        end
        f = k + h;
        while (l <= MAXV && !smp(f + l)) l++;
        if (l > MAXV) begin
            r.done_cyc = e0 + f + S + MAXV;
            return r;
        end
        r.phase    = k + S - 1;
        r.ton      = h;
        r.toff     = l;
        r.period   = (h + l > MAXV) ? MAXV : h + l;
        r.ovf      = 0;
        r.done_cyc = e0 + f + l + S;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding prediction
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("done_cycle", cyc,        mon_e.done_cyc);
                chk("phase_cyc",  phase_cyc,  mon_e.phase);
                chk("ton_cyc",    ton_cyc,    mon_e.ton);
                chk("toff_cyc",   toff_cyc,   mon_e.toff);
                chk("period_cyc", period_cyc, mon_e.period);
                chk("overflow",   overflow,   mon_e.ovf);
                chk("busy_at_done", busy,     0);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},   busy,       0);
        chk({tag, "_done"},   done,       0);
        chk({tag, "_ovf"},    overflow,   0);
        chk({tag, "_phase"},  phase_cyc,  0);
        chk({tag, "_ton"},    ton_cyc,    0);
        chk({tag, "_toff"},   toff_cyc,   0);
        chk({tag, "_period"}, period_cyc, 0);
    endtask

    // Drives wq after a start; rst_off >= 0 resets the DUT that many edges after start
    task automatic run_meas(input bit poke, input int rst_off);
        exp_t e;
        int   e0;
        int   last;
        int   n;
        repeat (5) begin
            @(negedge clk);
            start  = 1'b0;
            sig_in = wq[0];
        end
        @(negedge clk);
        start  = 1'b1;
        sig_in = wq[0];
        e0     = cyc + 1;
        e      = model(e0);
        if (rst_off < 0) begin
            sb_q.push_back(e);
            last = e.done_cyc + 2;
        end else begin
            last = e0 + rst_off + 4;
        end
        n = 1;
        do begin
            @(negedge clk);
            sig_in = smp(n);
            start  = 1'b0;
            if (n == 1) chk("busy_after_start", busy, 1);
            if (poke && cyc <= e.done_cyc) start = 1'($urandom_range(0, 1));
            if (rst_off >= 0 && cyc == e0 + rst_off - 1) begin
                rst   = 1'b1;
                start = 1'b1;
            end
            if (rst_off >= 0 && cyc == e0 + rst_off) begin
                rst = 1'b0;
                chk_zero("mid_reset");
            end
            n++;
        end while (cyc < last);
        if (rst_off < 0) begin
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL done_timeout: pending=%0d required=0 (cycle %0d)", sb_q.size(), cyc);
                sb_q.delete();
            end
        end
    endtask

    task automatic wave_10pct();
        wq.delete();
        put(1'b0, 5);
        repeat (3) begin
            put(1'b1, 1);
            put(1'b0, 9);
        end
        put(1'b1, 5);
    endtask

    initial begin
        int pre, g, h, l;
        rst    = 1'b1;
        start  = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst   = 1'b0;
        start = 1'b0;

        // 10% duty at period 10, first high sample 5 edges after start
        wave_10pct();
        run_meas(1'b0, -1);

        // 50% duty at period 4, repeated three times
        repeat (3) begin
            wq.delete();
            put(1'b0, 4);
            repeat (4) begin
                put(1'b1, 2);
                put(1'b0, 2);
            end
            put(1'b1, 4);
            run_meas(1'b1, -1);
        end

        // Already high at start: partial pulse must be skipped
        wq.delete();
        put(1'b1, 4); put(1'b0, 4); put(1'b1, 5); put(1'b0, 7); put(1'b1, 6);
        run_meas(1'b0, -1);

        // Saturation aborts in each counting phase
        wq.delete();
        put(1'b0, 600);
        run_meas(1'b0, -1);
        wq.delete();
        put(1'b0, 3); put(1'b1, 400); put(1'b0, 10);
        run_meas(1'b0, -1);
        wq.delete();
        put(1'b0, 3); put(1'b1, 4); put(1'b0, 400); put(1'b1, 5);
        run_meas(1'b0, -1);

        // Reset while counting the low phase, then a clean rerun
        wave_10pct();
        run_meas(1'b0, 11);
        wave_10pct();
        run_meas(1'b0, -1);

        // Period sum exceeds the counter width without aborting
        wq.delete();
        put(1'b0, 2); put(1'b1, 150); put(1'b0, 150); put(1'b1, 5);
        run_meas(1'b1, -1);

        // Randomized waveforms with spurious start pulses
        repeat (25) begin
            wq.delete();
            pre = int'($urandom_range(0, 1));
            g   = int'($urandom_range(0, 8));
            h   = int'($urandom_range(1, 40));
            l   = int'($urandom_range(1, 40));
            put(1'(pre), 1 + g);
            if (pre != 0) put(1'b0, int'($urandom_range(1, 5)));
            repeat (3) begin
                put(1'b1, h);
                put(1'b0, l);
            end
            put(1'b1, 8);
            run_meas(1'b1, -1);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clk_meas.md
CLK_MEAS -- requirements
Module: clk_meas

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of all measurement counters and result outputs.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, legal range 2..4: depth of the sig_in synchronizer.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sig_in  input  1  asynchronous clock/pulse waveform under measurement.
REQ-006 SHALL have port start  input  1  single-cycle request to begin one measurement.
REQ-007 SHALL have port busy  output  1  high while a measurement is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when results are updated.
REQ-009 SHALL have port phase_cyc  output  CNT_W  cycles from start acceptance to the detected rising edge.
REQ-010 SHALL have port ton_cyc  output  CNT_W  clk cycles the synchronized signal was high.
REQ-011 SHALL have port toff_cyc  output  CNT_W  clk cycles the synchronized signal was low.
REQ-012 SHALL have port period_cyc  output  CNT_W  ton_cyc + toff_cyc, saturating.
REQ-013 SHALL have port overflow  output  1  last measurement aborted on counter saturation.

Function
REQ-014 SHALL pass sig_in through a SYNC_STAGES-deep flop chain (s_sync), plus one extra flop (s_prev) for edge detection.
REQ-015 SHALL define rise = s_sync & ~s_prev and fall = ~s_sync & s_prev.
REQ-016 SHALL implement the FSM states IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW and FIN.
REQ-017 IDLE: start=1 -> WAIT_RISE on that edge, with the phase counter cleared; otherwise remain.
REQ-018 WAIT_RISE: increment the phase counter on every edge without rise; on rise -> MEAS_HIGH, with the high counter loaded to 1.
REQ-019 MEAS_HIGH: increment the high counter each edge without fall; on fall -> MEAS_LOW, with the low counter loaded to 1.
REQ-020 MEAS_LOW: increment the low counter each edge without rise; on rise -> FIN, latching all results.
REQ-021 FIN: done=1 for exactly this one cycle, then -> IDLE.
REQ-022 busy SHALL be 1 in WAIT_RISE, MEAS_HIGH and MEAS_LOW, and 0 in IDLE and FIN.
REQ-023 start SHALL be ignored in every state except IDLE, including FIN.
REQ-024 If sig_in is already high at start, the block SHALL wait for a low-then-high transition; no partial pulse is measured.
REQ-025 Results SHALL be latched only on entry to FIN and held unchanged until the next FIN or reset.
REQ-026 Any counter reaching all-ones while still counting SHALL force FIN on the next edge.
REQ-027 On such an abort, overflow=1 and all result outputs = all-ones.
REQ-028 On a normal completion, overflow=0.
REQ-029 period_cyc SHALL saturate to all-ones if ton_cyc+toff_cyc exceeds CNT_W bits; overflow is unaffected by this saturation alone.
REQ-030 Phase timing: start accepted at edge E0, sig_in first sampled high by stage 1 at edge E0+k -> phase_cyc = k+SYNC_STAGES-1.
REQ-031 Duty/period accuracy SHALL be +/-1 clk cycle versus sig_in's true edges; the synchronizer adds equal latency to both edges.

Reset
REQ-032 rst=1 at a rising edge SHALL force state IDLE, busy=0, done=0, overflow=0 and all result outputs and counters to 0.
REQ-033 The synchronizer and s_prev flops SHALL reset to 0.
REQ-034 Reset mid-measurement SHALL discard the measurement without a done pulse; the next start behaves as after power-up.
REQ-035 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-036 clk 100 MHz, sig_in 10 MHz, 10% duty, start once -> ton_cyc=1, toff_cyc=9, period_cyc=10, overflow=0, single done pulse.
REQ-037 sig_in 25 MHz, 50% duty -> ton_cyc=2, toff_cyc=2, period_cyc=4; repeat start 3x -> identical results each time.
REQ-038 SYNC_STAGES=2, sig_in low, first sampled high 5 edges after start -> phase_cyc=6.
REQ-039 CNT_W=8, sig_in held low after start -> done after phase counter reaches 255; overflow=1, all results=255, busy=0 afterwards.
REQ-040 rst pulsed while in MEAS_LOW -> no done, all outputs 0 next cycle; new start with 10 MHz 10% sig_in -> REQ-036 values.
REQ-041 start pulsed repeatedly while busy, and in the FIN cycle -> exactly one measurement and one done pulse per accepted start.
